// File: rtl/vram_dp_ctrl.sv
// vram_dp_ctrl: single-clock true dual-port video RAM with per-byte write
// enables, selectable read latency, collision arbitration and a clear engine.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   a_* (CPU/bus side)   req/we/be/addr/wdata in; ready/rvalid/rdata out
//   b_* (GPU side)       same as port A
//   b_collision          pulse: a port B byte was overridden by port A
//   clr_req              start a full-memory clear
//   clr_busy, clr_done   clear engine running / finished pulse
module vram_dp_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 13,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_ready,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_ready,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_collision,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic a_wr, a_rd, b_wr, b_rd;

  // Ports are held off only while the clear engine owns the array.
  assign a_ready = (state == IDLE);
  assign b_ready = (state == IDLE);

  assign a_wr = a_req && a_ready &&  a_we;
  assign a_rd = a_req && a_ready && !a_we;
  assign b_wr = b_req && b_ready &&  b_we;
  assign b_rd = b_req && b_ready && !b_we;

  // Clear engine FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CNT_LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array writes. Port A's byte assignments come after port B's so that on a
  // same-address collision A's enabled bytes win and B keeps the rest.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt[ADDR_W-1:0]] <= CLEAR_VAL;
    end
    for (int i = 0; i < BE_W; i++) begin
      if (b_wr && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

  // Stage p1: synchronous array read (read-first) and collision flag
  logic              a_vld_p1, b_vld_p1;
  logic [DATA_W-1:0] a_data_p1, b_data_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld_p1    <= 1'b0;
      b_vld_p1    <= 1'b0;
      a_data_p1   <= '0;
      b_data_p1   <= '0;
      b_collision <= 1'b0;
    end else begin
      a_vld_p1    <= a_rd;
      b_vld_p1    <= b_rd;
      if (a_rd) a_data_p1 <= mem[a_addr];
      if (b_rd) b_data_p1 <= mem[b_addr];
      b_collision <= a_wr && b_wr && (a_addr == b_addr) && (|(a_be & b_be));
    end
  end

  // Stage p2: optional output register
  if (OUT_REG != 0) begin : g_out_reg
    logic              a_vld_p2, b_vld_p2;
    logic [DATA_W-1:0] a_data_p2, b_data_p2;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        a_vld_p2  <= 1'b0;
        b_vld_p2  <= 1'b0;
        a_data_p2 <= '0;
        b_data_p2 <= '0;
      end else begin
        a_vld_p2 <= a_vld_p1;
        b_vld_p2 <= b_vld_p1;
        if (a_vld_p1) a_data_p2 <= a_data_p1;
        if (b_vld_p1) b_data_p2 <= b_data_p1;
      end
    end

    assign a_rvalid = a_vld_p2;
    assign a_rdata  = a_data_p2;
    assign b_rvalid = b_vld_p2;
    assign b_rdata  = b_data_p2;
  end else begin : g_no_out_reg
    assign a_rvalid = a_vld_p1;
    assign a_rdata  = a_data_p1;
    assign b_rvalid = b_vld_p1;
    assign b_rdata  = b_data_p1;
  end

endmodule

// File: tb/tb_vram_dp_ctrl.sv
// Testbench for vram_dp_ctrl: instance u_main uses the default geometry with
// single-cycle reads; instance u_small uses a 16-word array, the output
// register and a clear value of 16'h00FF.
module tb_vram_dp_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // u_main signals
  logic        a_req, a_we, a_ready, a_rvalid;
  logic [1:0]  a_be;
  logic [12:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_ready, b_rvalid, b_collision;
  logic [1:0]  b_be;
  logic [12:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic        clr_req, clr_busy, clr_done;

  // u_small signals
  logic        r_a_req, r_a_we, r_a_ready, r_a_rvalid;
  logic [1:0]  r_a_be;
  logic [3:0]  r_a_addr;
  logic [15:0] r_a_wdata, r_a_rdata;
  logic        r_b_req, r_b_we, r_b_ready, r_b_rvalid, r_b_collision;
  logic [1:0]  r_b_be;
  logic [3:0]  r_b_addr;
  logic [15:0] r_b_wdata, r_b_rdata;
  logic        r_clr_req, r_clr_busy, r_clr_done;

  int n_cmp = 0;
  int n_bad = 0;

  vram_dp_ctrl #(.DATA_W(16), .ADDR_W(13), .OUT_REG(0), .CLEAR_VAL(16'h0000)) u_main (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_collision(b_collision),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  vram_dp_ctrl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .CLEAR_VAL(16'h00FF)) u_small (
    .clk(clk), .reset_n(reset_n),
    .a_req(r_a_req), .a_we(r_a_we), .a_be(r_a_be), .a_addr(r_a_addr), .a_wdata(r_a_wdata),
    .a_ready(r_a_ready), .a_rvalid(r_a_rvalid), .a_rdata(r_a_rdata),
    .b_req(r_b_req), .b_we(r_b_we), .b_be(r_b_be), .b_addr(r_b_addr), .b_wdata(r_b_wdata),
    .b_ready(r_b_ready), .b_rvalid(r_b_rvalid), .b_rdata(r_b_rdata),
    .b_collision(r_b_collision),
    .clr_req(r_clr_req), .clr_busy(r_clr_busy), .clr_done(r_clr_done)
  );

  // u_small port A write: accepted on the posedge between the two negedges.
  task automatic r_write(input logic [3:0] ad, input logic [15:0] d);
    @(negedge clk);
    r_a_req = 1'b1; r_a_we = 1'b1; r_a_be = 2'b11; r_a_addr = ad; r_a_wdata = d;
    @(negedge clk);
    r_a_req = 1'b0; r_a_we = 1'b0;
  endtask

  // u_small port A read: accept edge, then data one edge later (output register).
  task automatic r_read(input logic [3:0] ad, output logic vld, output logic [15:0] d);
    @(negedge clk);
    r_a_req = 1'b1; r_a_we = 1'b0; r_a_addr = ad;
    @(posedge clk); #1;
    @(negedge clk);
    r_a_req = 1'b0;
    @(posedge clk); #1;
    vld = r_a_rvalid;
    d   = r_a_rdata;
  endtask

  task automatic r_prefill();
    for (int i = 0; i < 16; i++) r_write(4'(i), 16'hA500 + 16'(i));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_rvalid, b_rvalid, b_collision, clr_busy, clr_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {a_rvalid, b_rvalid, b_collision, clr_busy, clr_done});
    end
    n_cmp++;
    if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_rdata: a=%h b=%h want 0000", a_rdata, b_rdata);
    end
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || r_a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: a=%b b=%b r_a=%b want 1", a_ready, b_ready, r_a_ready);
    end
    n_cmp++;
    if ({r_a_rvalid, r_clr_busy, r_clr_done} !== 3'b0 || r_a_rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_small: flags=%b rdata=%h want 000/0000", {r_a_rvalid, r_clr_busy, r_clr_done}, r_a_rdata);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 13'h0123; a_wdata = 16'hBEEF;
    @(posedge clk); #1;
    n_cmp++;
    if (a_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_no_rvalid: rvalid=%b want 0", a_rvalid);
    end
    @(negedge clk);
    a_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rd_beef: rvalid=%b rdata=%h want 1 beef", a_rvalid, a_rdata);
    end
    @(negedge clk);
    a_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h want 0 beef", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_out_reg();
    r_write(4'h3, 16'hBEEF);
    @(negedge clk);
    r_a_req = 1'b1; r_a_we = 1'b0; r_a_addr = 4'h3;
    @(posedge clk); #1;
    n_cmp++;
    if (r_a_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL outreg_early: rvalid=%b want 0", r_a_rvalid);
    end
    @(negedge clk);
    r_a_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (r_a_rvalid !== 1'b1 || r_a_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL outreg_data: rvalid=%b rdata=%h want 1 beef", r_a_rvalid, r_a_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] ad [3];
    logic [15:0] ex [3];
    ad = '{13'h0200, 13'h0201, 13'h0200};
    ex = '{16'h0A0A, 16'h0B0B, 16'h0A0A};
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_be = 2'b11; b_addr = 13'h0200; b_wdata = 16'h0A0A;
    @(negedge clk);
    b_addr = 13'h0201; b_wdata = 16'h0B0B;
    @(negedge clk);
    b_req = 1'b0; b_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_req = 1'b1; a_we = 1'b0; a_addr = ad[k];
      @(posedge clk); #1;
      n_cmp++;
      if (a_rvalid !== 1'b1 || a_rdata !== ex[k]) begin
        n_bad++;
        $display("FAIL b2b_rd%0d: rvalid=%b rdata=%h want 1 %h", k, a_rvalid, a_rdata, ex[k]);
      end
      @(negedge clk);
    end
    a_req = 1'b0;
  endtask

  task automatic test_byte_enable();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 13'h0010; a_wdata = 16'h1234;
    @(negedge clk);
    a_be = 2'b10; a_wdata = 16'hAB00;
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 13'h0010;
    @(posedge clk); #1;
    n_cmp++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'hAB34) begin
      n_bad++;
      $display("FAIL byte_en: rvalid=%b rdata=%h want 1 ab34", b_rvalid, b_rdata);
    end
    @(negedge clk);
    b_req = 1'b0;
  endtask

  task automatic test_collision();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 13'h1FFF; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_be = 2'b11; b_addr = 13'h1FFF; b_wdata = 16'h2222;
    @(posedge clk); #1;
    n_cmp++;
    if (b_collision !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_pulse: b_collision=%b want 1", b_collision);
    end
    @(negedge clk);
    b_req = 1'b0; a_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_collision !== 1'b0 || a_rdata !== 16'h1111) begin
      n_bad++;
      $display("FAIL coll_full: b_collision=%b rdata=%h want 0 1111", b_collision, a_rdata);
    end
    @(negedge clk);
    a_we = 1'b1; a_be = 2'b01; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_be = 2'b10; b_wdata = 16'h2222;
    @(posedge clk); #1;
    n_cmp++;
    if (b_collision !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_disjoint: b_collision=%b want 0", b_collision);
    end
    @(negedge clk);
    b_req = 1'b0; a_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (a_rdata !== 16'h2211) begin
      n_bad++;
      $display("FAIL coll_merge: rdata=%h want 2211", a_rdata);
    end
    // Simultaneous writes to different addresses.
    @(negedge clk);
    a_we = 1'b1; a_be = 2'b11; a_addr = 13'h0300; a_wdata = 16'h3333;
    b_req = 1'b1; b_we = 1'b1; b_be = 2'b11; b_addr = 13'h0301; b_wdata = 16'h4444;
    @(posedge clk); #1;
    n_cmp++;
    if (b_collision !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_diff_addr: b_collision=%b want 0", b_collision);
    end
    @(negedge clk);
    a_we = 1'b0; b_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (a_rdata !== 16'h3333 || b_rdata !== 16'h4444) begin
      n_bad++;
      $display("FAIL diff_addr_rd: a=%h b=%h want 3333 4444", a_rdata, b_rdata);
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 13'h0040; a_wdata = 16'h0005;
    @(negedge clk);
    a_wdata = 16'h0006;
    b_req = 1'b1; b_we = 1'b0; b_addr = 13'h0040;
    @(posedge clk); #1;
    n_cmp++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'h0005) begin
      n_bad++;
      $display("FAIL rdw_old: rvalid=%b rdata=%h want 1 0005", b_rvalid, b_rdata);
    end
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_rdata !== 16'h0006) begin
      n_bad++;
      $display("FAIL rdw_new: rdata=%h want 0006", b_rdata);
    end
    @(negedge clk);
    b_req = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt, done_cyc, rdy_bad, rv_cnt, rv_cyc;
    logic [15:0] rv_data;
    logic        vld;
    logic [15:0] d;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; rdy_bad = 0;
    rv_cnt = 0; rv_cyc = -1; rv_data = '0;
    r_prefill();
    // Clear request together with a read of word 7 in the same idle cycle.
    @(negedge clk);
    r_clr_req = 1'b1;
    r_a_req = 1'b1; r_a_we = 1'b0; r_a_addr = 4'h7;
    for (int cyc = 0; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (r_clr_busy === 1'b1) begin
        busy_cnt++;
        if (r_a_ready !== 1'b0 || r_b_ready !== 1'b0) rdy_bad++;
      end
      if (r_clr_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (r_a_rvalid === 1'b1) begin
        rv_cnt++;
        rv_cyc  = cyc;
        rv_data = r_a_rdata;
      end
      if (cyc == 0) begin
        r_clr_req = 1'b0;
        r_a_req   = 1'b0;
      end
      r_clr_req = (cyc == 8);
    end
    n_cmp++;
    if (busy_cnt != 16) begin
      n_bad++;
      $display("FAIL clr_busy_len: got %0d cycles want 16", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != 16) begin
      n_bad++;
      $display("FAIL clr_done: pulses=%0d at cycle %0d want 1 at 16", done_cnt, done_cyc);
    end
    n_cmp++;
    if (rdy_bad != 0) begin
      n_bad++;
      $display("FAIL clr_ready: %0d busy cycles with ready high want 0", rdy_bad);
    end
    n_cmp++;
    if (rv_cnt != 1 || rv_cyc != 1 || rv_data !== 16'hA507) begin
      n_bad++;
      $display("FAIL clr_inflight: count=%0d cycle=%0d data=%h want 1 1 a507", rv_cnt, rv_cyc, rv_data);
    end
    n_cmp++;
    if (r_a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_ready_after: ready=%b want 1", r_a_ready);
    end
    for (int i = 0; i < 16; i++) begin
      r_read(4'(i), vld, d);
      n_cmp++;
      if (vld !== 1'b1 || d !== 16'h00FF) begin
        n_bad++;
        $display("FAIL clr_word%0d: rvalid=%b data=%h want 1 00ff", i, vld, d);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt, done_cnt;
    logic        vld;
    logic [15:0] d, ex;
    busy_cnt = 0; done_cnt = 0;
    r_prefill();
    @(negedge clk);
    r_clr_req = 1'b1;
    @(posedge clk); #1;
    r_clr_req = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (r_clr_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midclr_busy: busy=%b want 1", r_clr_busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({r_clr_busy, r_clr_done, r_a_rvalid, r_b_rvalid, r_b_collision} !== 5'b0 ||
        r_a_rdata !== 16'h0 || a_rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL midclr_async: flags=%b r_rdata=%h a_rdata=%h want 0",
               {r_clr_busy, r_clr_done, r_a_rvalid, r_b_rvalid, r_b_collision}, r_a_rdata, a_rdata);
    end
    n_cmp++;
    if (r_a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midclr_ready: ready=%b want 1", r_a_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (r_clr_busy === 1'b1) busy_cnt++;
      if (r_clr_done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL midclr_no_done: busy=%0d done=%0d want 0 0", busy_cnt, done_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      ex = (i < 5) ? 16'h00FF : (16'hA500 + 16'(i));
      r_read(4'(i), vld, d);
      n_cmp++;
      if (vld !== 1'b1 || d !== ex) begin
        n_bad++;
        $display("FAIL midclr_word%0d: rvalid=%b data=%h want 1 %h", i, vld, d, ex);
      end
    end
  endtask

  initial begin
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    clr_req = 0;
    r_a_req = 0; r_a_we = 0; r_a_be = '0; r_a_addr = '0; r_a_wdata = '0;
    r_b_req = 0; r_b_we = 0; r_b_be = '0; r_b_addr = '0; r_b_wdata = '0;
    r_clr_req = 0;
    test_reset();
    test_write_read();
    test_out_reg();
    test_back_to_back();
    test_byte_enable();
    test_collision();
    test_read_during_write();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vram_dp_ctrl.md
Name: vram_dp_ctrl

Overview:
- Parametrised single-clock dual-port VRAM for the GPU. Generalises the fixed 16-bit x 8K dual-port BSRAM to configurable width and depth.
- Adds per-byte write enables, selectable read latency, a write-collision policy and a hardware clear engine.
- Port A serves the CPU/bus bridge; port B serves the GPU renderer and scanout. Memory is inferred so synthesis maps it to BSRAM.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 13, address width; DEPTH = 2**ADDR_W words.
- OUT_REG, 0, 0 = read data 1 cycle after accept; 1 = extra output register, 2 cycles.
- CLEAR_VAL, 0, word written to every location by the clear engine.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request.
- a_we  in  1  port A write (1) / read (0).
- a_be  in  DATA_W/8  port A byte enables (writes only).
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_be, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as port A, for port B.
- b_collision  out  1  one-cycle pulse: port B write dropped by collision.
- clr_req  in  1  start clear of whole memory.
- clr_busy  out  1  clear engine running.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (reset_n low, async):
  - FSM goes to IDLE.
  - a_rvalid, b_rvalid, b_collision, clr_busy, clr_done = 0.
  - a_rdata, b_rdata = 0.
  - Clear address counter = 0.
  - Memory contents are not reset.
- Handshake: a request is accepted when x_req && x_ready at a rising edge. x_ready = 1 in IDLE and 0 in CLEAR; it is combinational from FSM state only.
- Writes: for each i, byte i of mem[addr] is updated when be[i] = 1. Unselected bytes are unchanged. Writes never raise rvalid.
- Reads: a read accepted in cycle N gives rvalid/rdata in N+1 when OUT_REG=0, or N+2 when OUT_REG=1.
  - Back-to-back reads keep full throughput, one per cycle per port.
  - rdata holds its last value while rvalid = 0.
- Read-during-write (either port, same or cross port, same address, same cycle): the read returns the old data (read-first).
- Write collision: A and B both write the same address in the same cycle.
  - Port A's bytes win.
  - Port B bytes not enabled in a_be are still written.
  - b_collision pulses in the next cycle when any b_be byte overlapped a_be.
  - Writes to different addresses proceed independently.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1. Counter is set to 0 and clr_busy rises in the next cycle.
  - In CLEAR, one word is written per cycle: mem[cnt] = CLEAR_VAL, then cnt++.
  - When cnt = DEPTH-1 is written, the FSM returns to IDLE and clr_done pulses for 1 cycle. A clear takes DEPTH cycles.
  - clr_req during CLEAR is ignored.
  - clr_req and a port request in the same IDLE cycle: the port request is accepted and clr_req also starts CLEAR.
- In-flight reads accepted before CLEAR still complete with their normal latency.
- Reset mid-clear returns the FSM to IDLE immediately. The memory is left partially cleared, no clr_done pulse is issued, and ports are ready after reset deasserts.
- Address arithmetic: the counter is ADDR_W+1 bits internally to detect the end; no wrap beyond DEPTH-1.

Test Plan:
- Write/read: A writes 16'hBEEF to 0x0123 with be=2'b11, then reads 0x0123 -> a_rvalid 1 cycle later with a_rdata=16'hBEEF. With OUT_REG=1 the response arrives 2 cycles later.
- Byte enables: write 16'h1234 to 0x0010, then A writes 16'hAB00 with be=2'b10 -> B reads 0x0010 = 16'hAB34.
- Collision: A writes 16'h1111 (be=11) and B writes 16'h2222 (be=11) to 0x1FFF in the same cycle -> memory = 16'h1111, b_collision pulses once. Repeat with a_be=01, b_be=10 -> memory 16'h2211, no pulse.
- Read-during-write: B reads 0x0040 (holding 16'h0005) while A writes 16'h0006 there -> b_rdata=16'h0005; a later read returns 16'h0006.
- Clear: CLEAR_VAL=16'h00FF, ADDR_W=4, pulse clr_req -> clr_busy high for 16 cycles, a_ready and b_ready low throughout, then clr_done pulses. All 16 words read 16'h00FF. A clr_req issued mid-clear does not extend it.
- Reset mid-clear: assert reset_n low at clear cycle 5 -> all outputs 0 immediately. Words 0-4 read CLEAR_VAL, word 5 onward keeps old data, no clr_done.
